// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings, FSM states and fault check for byte_data_memory.
`default_nettype none

package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } dmem_state_e;

  // High for misaligned halfword/word accesses and for the reserved size code.
  function automatic logic access_fault(input logic [1:0] size, input logic [1:0] offset);
    logic f;
    case (size)
      SZ_B:    f = 1'b0;
      SZ_H:    f = offset[0];
      SZ_W:    f = (offset != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: store byte-enable/lane replication and load lane extract/extend.
`default_nettype none

module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_lanes,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_en     = 4'b0000;
    store_lanes = 32'h0;
    case (size)
      SZ_B: begin
        byte_en     = 4'b0001 << offset;
        store_lanes = {4{store_data[7:0]}};
      end
      SZ_H: begin
        byte_en     = offset[1] ? 4'b1100 : 4'b0011;
        store_lanes = {2{store_data[15:0]}};
      end
      SZ_W: begin
        byte_en     = 4'b1111;
        store_lanes = store_data;
      end
      default: begin
        byte_en     = 4'b0000;
        store_lanes = 32'h0;
      end
    endcase
  end

  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0:    byte_sel = mem_word[7:0];
      2'd1:    byte_sel = mem_word[15:8];
      2'd2:    byte_sel = mem_word[23:16];
      default: byte_sel = mem_word[31:24];
    endcase
    half_sel = offset[1] ? mem_word[31:16] : mem_word[15:0];
  end

  always_comb begin
    load_data = 32'h0;
    case (size)
      SZ_B:    load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_H:    load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      SZ_W:    load_data = mem_word;
      default: load_data = 32'h0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/byte_data_memory.sv
// byte_data_memory: byte-addressable RV32I data memory with registered load response
// and a post-reset clear sequencer that zeroes one word per cycle.
`default_nettype none

module byte_data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH        = 64,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam dmem_state_e RST_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;

  reg [31:0] mem [DEPTH-1:0];

  dmem_state_e      state;
  logic [IDX_W-1:0] clr_idx;

  logic [IDX_W-1:0] idx;
  logic [1:0]       offset;
  logic             fault;
  logic             accept;
  logic             store_we;
  logic             clear_we;
  logic             rsp_due;
  logic [3:0]       byte_en;
  logic [31:0]      store_lanes;
  logic [31:0]      load_data;
  logic             unused_addr;

  // Addresses alias modulo 4*DEPTH; the bits above the index are intentionally dropped.
  assign idx         = req_addr[IDX_W+1:2];
  assign offset      = req_addr[1:0];
  assign unused_addr = ^req_addr[31:IDX_W+2];

  assign req_ready = (state == ST_RUN);
  assign busy      = (state == ST_CLEAR);

  assign fault    = access_fault(req_size, offset);
  assign accept   = req_valid && req_ready;
  assign store_we = accept && req_we && !fault;
  assign rsp_due  = accept && (!req_we || fault);
  assign clear_we = (state == ST_CLEAR) && !rst;

  dmem_lane_align u_align (
    .size        (req_size),
    .offset      (offset),
    .is_unsigned (req_unsigned),
    .store_data  (req_wdata),
    .mem_word    (mem[idx]),
    .byte_en     (byte_en),
    .store_lanes (store_lanes),
    .load_data   (load_data)
  );

  // Array has no reset; the clear sequencer owns it while in CLEAR.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clr_idx] <= 32'h0;
    end else if (store_we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[idx][8*b +: 8] <= store_lanes[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_STATE;
      clr_idx   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_fault <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          rsp_valid <= 1'b0;
          clr_idx   <= clr_idx + 1'b1;
          if (clr_idx == LAST_IDX) begin
            state <= ST_RUN;
          end
        end
        default: begin
          rsp_valid <= rsp_due;
          if (rsp_due) begin
            rsp_rdata <= fault ? 32'h0 : load_data;
            rsp_fault <= fault;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_byte_data_memory.sv
// tb_byte_data_memory: directed scoreboard bench for byte_data_memory (DEPTH=64, clear on reset).
`default_nettype none

module tb_byte_data_memory;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        busy;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    failures = 0;

  byte_data_memory #(.DEPTH(DEPTH), .CLEAR_ON_RST(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_fault    (rsp_fault),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Pops one scoreboard entry if a response is owed, otherwise requires silence.
  task automatic check_rsp();
    exp_t  e;
    string t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk({t, "_valid"}, {31'h0, rsp_valid}, 32'h1);
      chk({t, "_rdata"}, rsp_rdata, e.rdata);
      chk({t, "_fault"}, {31'h0, rsp_fault}, {31'h0, e.fault});
    end else begin
      chk("no_rsp", {31'h0, rsp_valid}, 32'h0);
    end
  endtask

  task automatic access(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic expect_rsp, input logic [31:0] exp_rdata, input logic exp_fault);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    if (expect_rsp) begin
      exp_q.push_back('{rdata: exp_rdata, fault: exp_fault});
      tag_q.push_back(tag);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_rsp();
  endtask

  task automatic store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
    access(tag, 1'b1, size, 1'b0, addr, wdata, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic load(input string tag, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] expv);
    access(tag, 1'b0, size, uns, addr, 32'h0, 1'b1, expv, 1'b0);
  endtask

  // Counts cycles with busy high starting from the negedge after rst drops.
  task automatic measure_clear(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_clear_cycles"}, n, DEPTH);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_fault", {31'h0, rsp_fault}, 32'h0);
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    measure_clear("boot");

    // Byte store/load
    store("sw10", 2'b10, 32'h10, 32'h11223344);
    store("sb12", 2'b00, 32'h12, 32'h000000AA);
    load("lw10", 2'b10, 1'b0, 32'h10, 32'h11AA3344);
    load("lb12", 2'b00, 1'b0, 32'h12, 32'hFFFFFFAA);
    load("lbu12", 2'b00, 1'b1, 32'h12, 32'h000000AA);
    load("lb10", 2'b00, 1'b0, 32'h10, 32'h00000044);
    load("lbu13", 2'b00, 1'b1, 32'h13, 32'h00000011);
    load("lh10", 2'b01, 1'b0, 32'h10, 32'h00003344);

    // Halfword
    store("sw20", 2'b10, 32'h20, 32'h1234CAFE);
    store("sh22", 2'b01, 32'h22, 32'h00008001);
    load("lh22", 2'b01, 1'b0, 32'h22, 32'hFFFF8001);
    load("lhu22", 2'b01, 1'b1, 32'h22, 32'h00008001);
    load("lw20", 2'b10, 1'b0, 32'h20, 32'h8001CAFE);

    // Faults
    access("sh21_fault", 1'b1, 2'b01, 1'b0, 32'h21, 32'h0000FFFF, 1'b1, 32'h0, 1'b1);
    load("lw20_after_fault", 2'b10, 1'b0, 32'h20, 32'h8001CAFE);
    access("lw06_fault", 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b1, 32'h0, 1'b1);
    access("sz11_ld_fault", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1);
    access("sz11_st_fault", 1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1);
    load("lw10_after_sz11", 2'b10, 1'b0, 32'h10, 32'h11AA3344);

    // Write-then-read and aliasing
    store("sw04", 2'b10, 32'h04, 32'hDEADBEEF);
    load("lw04", 2'b10, 1'b0, 32'h04, 32'hDEADBEEF);
    load("lw04_alias", 2'b10, 1'b0, 32'h04 + 4 * DEPTH, 32'hDEADBEEF);
    load("lw04_alias_hi", 2'b10, 1'b0, 32'h80000004, 32'hDEADBEEF);

    // Reset clears contents
    store("sw14", 2'b10, 32'h14, 32'h55AA55AA);
    load("lw14_pre", 2'b10, 1'b0, 32'h14, 32'h55AA55AA);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    measure_clear("rst2");
    load("lw14_cleared", 2'b10, 1'b0, 32'h14, 32'h0);
    load("lw04_cleared", 2'b10, 1'b0, 32'h04, 32'h0);

    // Reset mid-clear, with requests ignored during clear
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = i[0];
      req_size  = 2'b10;
      req_addr  = 32'h14;
      req_wdata = 32'hA5A5A5A5;
      @(posedge clk);
      #1;
      check_rsp();
    end
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midclr_busy", {31'h0, busy}, 32'h1);
    chk("midclr_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    measure_clear("midclr");
    load("lw14_after_midclr", 2'b10, 1'b0, 32'h14, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
